frame_max_reducer: RTL
======================

# frame_max_reducer

Streaming magnitude-maximum reducer for IEEE-754 single-precision values in the MFCC datapath. It accepts one float per cycle through a valid/ready handshake. Over each frame of `FRAME_LEN` samples it tracks the largest-magnitude sample and its index, then presents the result on a held valid/ready output. It sits upstream of the normalisation/log stages that scale a frame by its peak, and applies the team's pairwise max-compare rule (exponent first, then significand, new sample wins ties).

## Interface

Parameters:
- `DATA_WIDTH`, 32, sample width; fixed IEEE-754 single layout (sign 31, exponent 30:23, significand 22:0).
- `FRAME_LEN`, 512, samples per frame; must be ≥ 2.
- `IDX_WIDTH`, 9, width of sample index; must satisfy 2^`IDX_WIDTH` ≥ `FRAME_LEN`.

Ports:
- `clk`, input, 1, single clock; all logic on rising edge.
- `rst`, input, 1, reset, asynchronous and active-high.
- `clear`, input, 1, synchronous frame abort.
- `in_valid`, input, 1, `in_data` valid.
- `in_ready`, output, 1, block accepts a sample this cycle (registered).
- `in_data`, input, `DATA_WIDTH`, sample.
- `out_valid`, output, 1, frame result valid (registered).
- `out_ready`, input, 1, consumer accepts result.
- `out_max`, output, `DATA_WIDTH`, selected sample, all 32 bits verbatim including sign.
- `out_index`, output, `IDX_WIDTH`, index (0-based, within the frame) of `out_max`.

## Operation

- Transfer means `in_valid && in_ready` at a rising edge.
- Compare rule: magnitude only; sign bit ignored.
  - Candidate replaces the running max when its exponent is greater.
  - With equal exponents, the candidate replaces it when its significand is ≥ the running max's significand.
  - This is equivalent to an unsigned compare of bits 30:0, with ties resolved to the newer sample.
- No special handling for NaN, Inf or denormals: exponent 0xFF is simply the largest exponent.
- State `ACCUM`:
  - `in_ready`=1.
  - On a transfer with `count`==0: load `run_max`=`in_data` and `run_idx`=0 unconditionally.
  - On any other transfer: apply the compare rule and update `run_idx`=`count` on replace.
  - `count` increments on each transfer.
- Frame end: a transfer with `count`==`FRAME_LEN`-1 updates `run_max`/`run_idx` as above, copies the post-update values to `out_max`/`out_index`, and then:
  - sets `out_valid`=1 and `in_ready`=0,
  - clears `count`,
  - moves to `HOLD`.
- State `HOLD`:
  - `out_valid`, `out_max` and `out_index` are held stable.
  - `in_valid` is ignored.
  - On `out_valid && out_ready`: `out_valid`=0, `in_ready`=1, go to `ACCUM`.
- `clear`, state `ACCUM`: `count`=0 and the partial frame is discarded. A transfer in the same cycle is discarded (clear wins).
- `clear`, state `HOLD`: `out_valid`=0, `in_ready`=1, go to `ACCUM`. The pending result is dropped even if `out_ready` is high.
- `count` never wraps past `FRAME_LEN`-1; the frame end always routes through `HOLD`.

## Timing

- Reset (`rst`=1, takes effect immediately):
  - state=`ACCUM`, `count`=0,
  - `in_ready`=0, `out_valid`=0, `out_max`=0, `out_index`=0, `run_max`=0, `run_idx`=0.
- `in_ready` rises at the first rising edge after `rst` deasserts.
- Result latency: `out_valid` is 1 in the cycle immediately after the edge that accepted the last sample of the frame.
- `in_ready` is 0 from that same cycle until the cycle after the output handshake.
- Minimum frame period is `FRAME_LEN`+1 cycles when `out_ready` is tied high.
- Output handshake completes at the edge where `out_valid && out_ready`. The next sample can be accepted at the following edge.
- Asserting `rst` mid-frame or in `HOLD` discards all state; no partial result is emitted.

## Test plan

Bench uses `FRAME_LEN`=4, `IDX_WIDTH`=2.

- Reset: assert `rst` mid-stream → `out_valid`=0, `out_max`=0, `out_index`=0 and `in_ready`=0 asynchronously; `in_ready`=1 one edge after release.
- Basic frame: send 0x3F800000, 0x40400000, 0x40000000, 0x3F000000 back-to-back with `out_ready`=1 → next cycle `out_valid`=1, `out_max`=0x40400000, `out_index`=1; `in_ready` low exactly one cycle.
- Tie and sign: send 0x40000000, 0x3F800000, 0x40000000, 0x3F000000 → `out_index`=2. Then send 0x40400000, 0xC0800000, 0x00000000, 0x7F800000 → `out_max`=0x7F800000, `out_index`=3. Then send 0x40400000, 0xC0800000, 0x3F800000, 0x3F800000 → `out_max`=0xC0800000, `out_index`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after frame end while pulsing `in_valid` → `out_valid`, `out_max` and `out_index` stable, no samples accepted, `count` stays 0. Raise `out_ready` → next cycle `out_valid`=0, `in_ready`=1.
- Clear: after 2 accepted samples, assert `clear` together with a third transfer of 0x7F000000 → that sample is discarded; the next 4 samples form the frame and the result ignores all three earlier samples. `clear` in `HOLD` with `out_ready`=1 → result dropped, no handshake counted.

Source files
------------

// File: rtl/frame_max_reducer.sv
// frame_max_reducer: per-frame largest-magnitude float and its index, held on a valid/ready output
module frame_max_reducer #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 512,
    parameter int IDX_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [IDX_WIDTH-1:0]  out_index
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t                r_state;
    logic [IDX_WIDTH-1:0]  r_count;
    logic [DATA_WIDTH-1:0] r_run_max;
    logic [IDX_WIDTH-1:0]  r_run_idx;
    logic                  w_xfer;
    logic                  w_first;
    logic                  w_last;
    logic                  w_replace;
    logic [DATA_WIDTH-1:0] w_new_max;
    logic [IDX_WIDTH-1:0]  w_new_idx;
    // magnitude order is an unsigned compare of everything below the sign; ties go to the newer sample
    always_comb begin
        w_xfer    = in_valid && in_ready && r_state == ACCUM;
        w_first   = r_count == '0;
        w_last    = r_count == IDX_WIDTH'(FRAME_LEN - 1);
        w_replace = in_data[DATA_WIDTH-2:0] >= r_run_max[DATA_WIDTH-2:0];
        w_new_max = (w_first || w_replace) ? in_data : r_run_max;
        w_new_idx = w_first ? '0 : w_replace ? r_count : r_run_idx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ACCUM;
            r_count   <= '0;
            r_run_max <= '0;
            r_run_idx <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_index <= '0;
        end else if (r_state == ACCUM) begin
            in_ready <= 1'b1;
            if (clear) begin
                r_count <= '0;
            end else if (w_xfer) begin
                r_run_max <= w_new_max;
                r_run_idx <= w_new_idx;
                r_count   <= w_last ? '0 : r_count + 1'b1;
                if (w_last) begin
                    out_max   <= w_new_max;
                    out_index <= w_new_idx;
                    out_valid <= 1'b1;
                    in_ready  <= 1'b0;
                    r_state   <= HOLD;
                end
            end
        end else if (clear || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ACCUM;
        end
    end
endmodule
